// File: rtl/timer_multi.sv
// timer_multi: NUM_CH independent prescaled up-counters with compare, one-shot or
// periodic mode and sticky pending flags. The registers sit on the shared peripheral
// bus and raise a per-channel interrupt plus a combined interrupt.
module timer_multi #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          PRESC_W   = 16,
  parameter logic [31:0] BASE_ADDR = 32'hffff0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  inout  wire  [31:0]       mem_data,
  output logic [NUM_CH-1:0] timer_irq,
  output logic              timer_int
);

  // The window holds 16 bytes per channel followed by the STATUS word.
  localparam logic [31:0] WIN_BYTES = 32'(16 * NUM_CH + 4);
  localparam logic [31:0] STAT_OFF  = 32'(16 * NUM_CH);

  // Register map offsets within a channel's 16-byte slot.
  typedef enum logic [1:0] {
    REG_COUNT = 2'd0,
    REG_CMP   = 2'd1,
    REG_CTRL  = 2'd2,
    REG_PRESC = 2'd3
  } reg_sel_e;

  // Address decode. Subtracting the base first means addresses below the base
  // wrap to huge offsets and fall outside the window naturally.
  logic [31:0] offset;
  logic        in_win;
  logic        aligned;
  logic        stat_hit;
  reg_sel_e    reg_sel;
  logic [31:0] wdata;

  assign offset   = mem_addr - BASE_ADDR;
  assign in_win   = (offset < WIN_BYTES);
  assign aligned  = (offset[1:0] == 2'b00);
  assign stat_hit = in_win && (offset == STAT_OFF);
  assign reg_sel  = reg_sel_e'(offset[3:2]);
  assign wdata    = mem_data;

  logic wr_stat;
  assign wr_stat = mem_we && stat_hit;

  // Per-channel state.
  logic [CNT_W-1:0]   cnt   [NUM_CH];
  logic [CNT_W-1:0]   cmp   [NUM_CH];
  logic [PRESC_W-1:0] presc [NUM_CH];
  logic [PRESC_W-1:0] pcnt  [NUM_CH];
  logic [NUM_CH-1:0]  en;
  logic [NUM_CH-1:0]  ie;
  logic [NUM_CH-1:0]  pend;
  logic [NUM_CH-1:0]  mode;

  // Per-channel decode and event terms.
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_cnt;
  logic [NUM_CH-1:0] wr_cmp;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_presc;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] clr_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_hit[g]   = in_win && aligned && (offset[31:4] == 28'(g));
    assign wr_cnt[g]   = mem_we && ch_hit[g] && (reg_sel == REG_COUNT);
    assign wr_cmp[g]   = mem_we && ch_hit[g] && (reg_sel == REG_CMP);
    assign wr_ctrl[g]  = mem_we && ch_hit[g] && (reg_sel == REG_CTRL);
    assign wr_presc[g] = mem_we && ch_hit[g] && (reg_sel == REG_PRESC);
    // The prescaler has reached its terminal value: advance the counter this edge.
    assign tick[g]     = en[g] && (pcnt[g] == presc[g]);
    // A software COUNT write in the same cycle overrides the tick, so no expiry then.
    assign expire[g]   = tick[g] && !wr_cnt[g] && (cnt[g] >= cmp[g]);
    assign clr_pend[g] = (wr_ctrl[g] && wdata[2]) || (wr_stat && wdata[g]);
  end

  // Channel state update: prescaler, counter, compare, control and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-channel arrays are a handful of flops rather than a RAM, so they
      // take the asynchronous reset like every other register here.
      for (int n = 0; n < NUM_CH; n++) begin
        cnt[n]   <= '0;
        cmp[n]   <= '0;
        presc[n] <= '0;
        pcnt[n]  <= '0;
      end
      en   <= '0;
      ie   <= '0;
      pend <= '0;
      mode <= '0;
    end else begin
      // NOTE: non-blocking assignments so every term below sees the pre-edge state,
      // which is what makes the same-cycle collision priorities hold.
      for (int n = 0; n < NUM_CH; n++) begin
        // A COUNT or PRESC write restarts the prescale phase.
        if (wr_cnt[n] || wr_presc[n]) begin
          pcnt[n] <= '0;
        end else if (tick[n]) begin
          pcnt[n] <= '0;
        end else if (en[n]) begin
          pcnt[n] <= pcnt[n] + PRESC_W'(1);
        end

        if (wr_cnt[n]) begin
          cnt[n] <= wdata[CNT_W-1:0];
        end else if (expire[n]) begin
          cnt[n] <= '0;
        end else if (tick[n]) begin
          cnt[n] <= cnt[n] + CNT_W'(1);
        end

        if (wr_cmp[n]) begin
          cmp[n] <= wdata[CNT_W-1:0];
        end

        if (wr_presc[n]) begin
          presc[n] <= wdata[PRESC_W-1:0];
        end

        // A software CTRL write beats the one-shot self-disable.
        if (wr_ctrl[n]) begin
          en[n]   <= wdata[0];
          ie[n]   <= wdata[1];
          mode[n] <= wdata[3];
        end else if (expire[n] && !mode[n]) begin
          en[n] <= 1'b0;
        end

        // A hardware expiry beats a software clear in the same cycle.
        if (expire[n]) begin
          pend[n] <= 1'b1;
        end else if (clr_pend[n]) begin
          pend[n] <= 1'b0;
        end
      end
    end
  end

  // Read mux: select the addressed register, zero-extended; unaligned hits read 0.
  logic [31:0] rdata;

  always_comb begin
    // NOTE: default first so every path assigns rdata and no latch is inferred.
    rdata = '0;
    if (stat_hit) begin
      rdata = 32'(pend);
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_hit[n]) begin
          case (reg_sel)
            REG_COUNT: rdata = 32'(cnt[n]);
            REG_CMP:   rdata = 32'(cmp[n]);
            REG_CTRL:  rdata = {28'd0, mode[n], pend[n], ie[n], en[n]};
            REG_PRESC: rdata = 32'(presc[n]);
            default:   rdata = '0;
          endcase
        end
      end
    end
  end

  // The bus is only driven for reads that land inside the window.
  assign mem_data = (!mem_we && in_win) ? rdata : 32'bz;

  assign timer_irq = pend & ie;
  assign timer_int = |timer_irq;

endmodule
